// File: rtl/unit_slot_scheduler_pkg.sv
// Shared definitions for the unit slot scheduler: slot geometry, unit type codes and scheduler states.
package unit_slot_scheduler_pkg;

  localparam int NUM_SLOTS = 16;
  localparam int LOC_W     = 9;
  localparam int IDX_W     = $clog2(NUM_SLOTS);
  localparam int CNT_W     = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {
    UT_EMPTY = 2'b00,
    UT_CAT0  = 2'b01,
    UT_CAT1  = 2'b10,
    UT_ENEMY = 2'b11
  } unit_type_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sched_state_e;

  function automatic logic is_cat(input unit_type_e t);
    return (t == UT_CAT0) || (t == UT_CAT1);
  endfunction

endpackage

// File: rtl/unit_slot_scheduler_prio_enc.sv
// Lowest-index free-slot finder: empty mask in, slot index plus "nothing free" flag out.
module slot_priority_enc
  import unit_slot_scheduler_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] empty_mask,
  output logic [IDX_W-1:0]     free_idx,
  output logic                 none_free
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    free_idx  = '0;
    none_free = 1'b1;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (empty_mask[i]) begin
        free_idx  = IDX_W'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/unit_slot_scheduler.sv
// Owns the on-screen unit slots: arbitrates cat/enemy spawns into free slots and
// sweeps every live unit one step per game tick, retiring units that reach the opposing base.
module unit_slot_scheduler
  import unit_slot_scheduler_pkg::*;
#(
  parameter logic [LOC_W-1:0] CAT_BASE_LOC   = 9'd440,
  parameter logic [LOC_W-1:0] ENEMY_BASE_LOC = 9'd40,
  parameter int               CAT_STEP       = 2,
  parameter int               ENEMY_STEP     = 1
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gameSCEN,
  input  logic                       cat_req,
  input  logic [1:0]                 cat_type,
  input  logic                       enemy_req,
  output logic                       cat_ack,
  output logic                       enemy_ack,
  output logic                       slots_full,
  output logic [CNT_W-1:0]           unit_count,
  output logic                       base_hit_cat,
  output logic                       base_hit_enemy,
  output logic                       tick_overrun,
  output logic [NUM_SLOTS*LOC_W-1:0] unit_loc_flat,
  output logic [2*NUM_SLOTS-1:0]     unit_type_flat
);

  localparam logic [LOC_W:0] CAT_RETIRE_X = {1'b0, ENEMY_BASE_LOC} + (LOC_W+1)'(CAT_STEP);
  localparam logic [LOC_W:0] CAT_BASE_X   = {1'b0, CAT_BASE_LOC};
  localparam logic [LOC_W:0] EN_STEP_X    = (LOC_W+1)'(ENEMY_STEP);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rr_enemy_last_q;

  unit_type_e       slot_type_q [NUM_SLOTS];
  logic [LOC_W-1:0] slot_loc_q  [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] empty_mask;
  logic [IDX_W-1:0]     free_idx;
  logic                 none_free;

  logic             cat_pend, enemy_pend, spawn_ok, grant_cat, grant_enemy;
  logic             sweep_live, retire_cat, retire_enemy, overrun_d;
  unit_type_e       cur_type, cat_type_eff;
  logic [LOC_W-1:0] cur_loc, moved_loc;
  logic [LOC_W:0]   cur_loc_x;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) empty_mask[i] = (slot_type_q[i] == UT_EMPTY);
  end

  slot_priority_enc u_prio (
    .empty_mask (empty_mask),
    .free_idx   (free_idx),
    .none_free  (none_free)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (gameSCEN) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_SLOTS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A requester whose ack is showing has already been served and is about to drop req.
  always_comb begin
    cat_pend     = cat_req & ~cat_ack;
    enemy_pend   = enemy_req & ~enemy_ack;
    spawn_ok     = (state_q == ST_IDLE) & ~gameSCEN & ~none_free;
    grant_cat    = spawn_ok & cat_pend & (~enemy_pend | rr_enemy_last_q);
    grant_enemy  = spawn_ok & enemy_pend & ~grant_cat;
    cat_type_eff = (cat_type == 2'b00) ? UT_CAT0 : unit_type_e'(cat_type);

    cur_type     = slot_type_q[idx_q];
    cur_loc      = slot_loc_q[idx_q];
    cur_loc_x    = {1'b0, cur_loc};
    sweep_live   = (state_q == ST_SWEEP) & (cur_type != UT_EMPTY);
    retire_cat   = sweep_live & is_cat(cur_type) & (cur_loc_x <= CAT_RETIRE_X);
    retire_enemy = sweep_live & (cur_type == UT_ENEMY) & ((cur_loc_x + EN_STEP_X) >= CAT_BASE_X);
    moved_loc    = is_cat(cur_type) ? cur_loc - LOC_W'(CAT_STEP) : cur_loc + LOC_W'(ENEMY_STEP);
    overrun_d    = (state_q == ST_SWEEP) & gameSCEN;

    count_d      = unit_count + CNT_W'(grant_cat | grant_enemy) - CNT_W'(retire_cat | retire_enemy);
  end

  // Spawns only happen in IDLE and retires only in SWEEP, so at most one slot changes per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_type_q[i] <= UT_EMPTY;
        slot_loc_q[i]  <= '0;
      end
    end else if (grant_cat) begin
      slot_type_q[free_idx] <= cat_type_eff;
      slot_loc_q[free_idx]  <= CAT_BASE_LOC;
    end else if (grant_enemy) begin
      slot_type_q[free_idx] <= UT_ENEMY;
      slot_loc_q[free_idx]  <= ENEMY_BASE_LOC;
    end else if (retire_cat || retire_enemy) begin
      slot_type_q[idx_q] <= UT_EMPTY;
      slot_loc_q[idx_q]  <= '0;
    end else if (sweep_live) begin
      slot_loc_q[idx_q]  <= moved_loc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cat_ack         <= 1'b0;
      enemy_ack       <= 1'b0;
      base_hit_cat    <= 1'b0;
      base_hit_enemy  <= 1'b0;
      tick_overrun    <= 1'b0;
      rr_enemy_last_q <= 1'b1;
      unit_count      <= '0;
      slots_full      <= 1'b0;
    end else begin
      cat_ack        <= grant_cat;
      enemy_ack      <= grant_enemy;
      base_hit_cat   <= retire_enemy;
      base_hit_enemy <= retire_cat;
      tick_overrun   <= overrun_d;
      if (grant_cat)        rr_enemy_last_q <= 1'b0;
      else if (grant_enemy) rr_enemy_last_q <= 1'b1;
      unit_count     <= count_d;
      slots_full     <= (count_d == CNT_W'(NUM_SLOTS));
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
    assign unit_loc_flat[g*LOC_W +: LOC_W] = slot_loc_q[g];
    assign unit_type_flat[2*g +: 2]        = slot_type_q[g];
  end

endmodule

// File: tb/tb_unit_slot_scheduler.sv
// Randomised scoreboard bench for unit_slot_scheduler against a slot-array reference model.
module tb_unit_slot_scheduler;

  localparam int NS       = 16;
  localparam int CAT_BASE = 440;
  localparam int EN_BASE  = 40;
  localparam int CSTEP    = 2;
  localparam int ESTEP    = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         gameSCEN = 1'b0, cat_req = 1'b0, enemy_req = 1'b0;
  logic [1:0]   cat_type = 2'b01;
  logic         cat_ack, enemy_ack, slots_full, base_hit_cat, base_hit_enemy, tick_overrun;
  logic [4:0]   unit_count;
  logic [143:0] unit_loc_flat;
  logic [31:0]  unit_type_flat;

  unit_slot_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .gameSCEN       (gameSCEN),
    .cat_req        (cat_req),
    .cat_type       (cat_type),
    .enemy_req      (enemy_req),
    .cat_ack        (cat_ack),
    .enemy_ack      (enemy_ack),
    .slots_full     (slots_full),
    .unit_count     (unit_count),
    .base_hit_cat   (base_hit_cat),
    .base_hit_enemy (base_hit_enemy),
    .tick_overrun   (tick_overrun),
    .unit_loc_flat  (unit_loc_flat),
    .unit_type_flat (unit_type_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         slot;
    logic [1:0] typ;
    logic [8:0] loc;
  } ev_t;

  int   checks = 0, errors = 0;
  ev_t  q_cat[$], q_en[$];
  int   q_hc[$], q_he[$], q_ov[$];
  int   hits_cat_seen = 0, hits_en_seen = 0;

  logic [1:0] m_type [NS];
  int         m_loc  [NS];
  bit         m_last_enemy, p_cat, p_en;
  logic [1:0] p_cat_type;

  task automatic chk(input string name, input logic [175:0] act, input logic [175:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_type[i] = 2'b00;
      m_loc[i]  = 0;
    end
    m_last_enemy = 1'b1;
    p_cat = 1'b0;
    p_en  = 1'b0;
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < NS; i++) if (m_type[i] == 2'b00) return i;
    return -1;
  endfunction

  task automatic model_grants();
    int  s;
    bit  cat_wins;
    ev_t e;
    while (p_cat || p_en) begin
      s = lowest_free();
      if (s < 0) break;
      if (p_cat && p_en) cat_wins = m_last_enemy;
      else               cat_wins = p_cat;
      e.slot = s;
      if (cat_wins) begin
        m_type[s] = (p_cat_type == 2'b00) ? 2'b01 : p_cat_type;
        m_loc[s]  = CAT_BASE;
        e.typ = m_type[s];
        e.loc = 9'(CAT_BASE);
        q_cat.push_back(e);
        p_cat = 1'b0;
        m_last_enemy = 1'b0;
      end else begin
        m_type[s] = 2'b11;
        m_loc[s]  = EN_BASE;
        e.typ = 2'b11;
        e.loc = 9'(EN_BASE);
        q_en.push_back(e);
        p_en = 1'b0;
        m_last_enemy = 1'b1;
      end
    end
  endtask

  // One game tick: cats walk left, enemies walk right; a unit whose step would reach the far base is removed.
  task automatic model_sweep();
    for (int i = 0; i < NS; i++) begin
      if (m_type[i] == 2'b01 || m_type[i] == 2'b10) begin
        if (m_loc[i] - CSTEP <= EN_BASE) begin
          m_type[i] = 2'b00;
          m_loc[i]  = 0;
          q_he.push_back(i);
        end else m_loc[i] = m_loc[i] - CSTEP;
      end else if (m_type[i] == 2'b11) begin
        if (m_loc[i] + ESTEP >= CAT_BASE) begin
          m_type[i] = 2'b00;
          m_loc[i]  = 0;
          q_hc.push_back(i);
        end else m_loc[i] = m_loc[i] + ESTEP;
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    ev_t e;
    int  s;
    if (rst === 1'b0) begin
      if (cat_ack) begin
        if (q_cat.size() == 0) chk("cat_ack_spurious", 176'(cat_ack), 176'(0));
        else begin
          e = q_cat.pop_front();
          chk("cat_ack_slot", 176'({unit_type_flat[2*e.slot +: 2], unit_loc_flat[9*e.slot +: 9]}),
              176'({e.typ, e.loc}));
        end
      end
      if (enemy_ack) begin
        if (q_en.size() == 0) chk("enemy_ack_spurious", 176'(enemy_ack), 176'(0));
        else begin
          e = q_en.pop_front();
          chk("enemy_ack_slot", 176'({unit_type_flat[2*e.slot +: 2], unit_loc_flat[9*e.slot +: 9]}),
              176'({e.typ, e.loc}));
        end
      end
      if (base_hit_enemy) begin
        hits_en_seen++;
        if (q_he.size() == 0) chk("base_hit_enemy_spurious", 176'(base_hit_enemy), 176'(0));
        else begin
          s = q_he.pop_front();
          chk("base_hit_enemy_slot_freed", 176'({unit_type_flat[2*s +: 2], unit_loc_flat[9*s +: 9]}), 176'(0));
        end
      end
      if (base_hit_cat) begin
        hits_cat_seen++;
        if (q_hc.size() == 0) chk("base_hit_cat_spurious", 176'(base_hit_cat), 176'(0));
        else begin
          s = q_hc.pop_front();
          chk("base_hit_cat_slot_freed", 176'({unit_type_flat[2*s +: 2], unit_loc_flat[9*s +: 9]}), 176'(0));
        end
      end
      if (tick_overrun) begin
        if (q_ov.size() == 0) chk("tick_overrun_spurious", 176'(tick_overrun), 176'(0));
        else s = q_ov.pop_front();
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(negedge clk);
    if (cat_ack)   cat_req   = 1'b0;
    if (enemy_ack) enemy_req = 1'b0;
    gameSCEN = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [143:0] el;
    logic [31:0]  et;
    int           cnt;
    cnt = 0;
    for (int i = 0; i < NS; i++) begin
      el[9*i +: 9] = m_loc[i][8:0];
      et[2*i +: 2] = m_type[i];
      if (m_type[i] != 2'b00) cnt++;
    end
    chk({tag, "_types"}, 176'(unit_type_flat), 176'(et));
    chk({tag, "_locs"}, 176'(unit_loc_flat), 176'(el));
    chk({tag, "_unit_count"}, 176'(unit_count), 176'(cnt));
    chk({tag, "_slots_full"}, 176'(slots_full), 176'(cnt == NS));
    chk({tag, "_events_missing"}, 176'(q_cat.size() + q_en.size() + q_hc.size() + q_he.size() + q_ov.size()), 176'(0));
  endtask

  task automatic spawn(input bit c, input bit e, input logic [1:0] t);
    if (c && !p_cat && !cat_req) begin
      cat_type = t;
      cat_req = 1'b1;
      p_cat = 1'b1;
      p_cat_type = t;
    end
    if (e && !p_en && !enemy_req) begin
      enemy_req = 1'b1;
      p_en = 1'b1;
    end
    model_grants();
    repeat (6) step();
  endtask

  task automatic tick(input int ov_at);
    model_sweep();
    model_grants();
    if (ov_at >= 0) q_ov.push_back(ov_at);
    gameSCEN = 1'b1;
    step();
    for (int c = 0; c < 16; c++) begin
      if (c == ov_at) gameSCEN = 1'b1;
      step();
    end
    repeat (5) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cat_req = 1'b0;
    enemy_req = 1'b0;
    gameSCEN = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_clear();
    step();
  endtask

  initial begin
    int op, ov, hc0, he0;
    model_clear();
    rst = 1'b1;
    step();
    step();
    chk("reset_types", 176'(unit_type_flat), 176'(0));
    chk("reset_locs", 176'(unit_loc_flat), 176'(0));
    chk("reset_ctrl_outputs",
        176'({cat_ack, enemy_ack, slots_full, unit_count, base_hit_cat, base_hit_enemy, tick_overrun}), 176'(0));
    rst = 1'b0;
    step();

    // single cat spawn, ack one cycle after the request
    cat_type = 2'b01;
    cat_req = 1'b1;
    p_cat = 1'b1;
    p_cat_type = 2'b01;
    model_grants();
    step();
    chk("t1_ack_latency", 176'(cat_ack), 176'(1));
    repeat (5) step();
    chk("t1_slot0", 176'({unit_type_flat[1:0], unit_loc_flat[8:0]}), 176'({2'b01, 9'd440}));
    chk("t1_count", 176'(unit_count), 176'(1));
    check_state("t1");

    // simultaneous requests alternate, cat first after reset
    do_reset();
    spawn(1'b1, 1'b1, 2'b10);
    chk("t2_slot0_cat", 176'({unit_type_flat[1:0], unit_loc_flat[8:0]}), 176'({2'b10, 9'd440}));
    chk("t2_slot1_enemy", 176'({unit_type_flat[3:2], unit_loc_flat[17:9]}), 176'({2'b11, 9'd40}));
    check_state("t2a");
    spawn(1'b1, 1'b1, 2'b00);
    chk("t2_slot2_cat_type00", 176'({unit_type_flat[5:4], unit_loc_flat[26:18]}), 176'({2'b01, 9'd440}));
    check_state("t2b");

    // tick with an overrun strobe at sweep cycle 5
    tick(5);
    chk("t3_slot0_loc", 176'(unit_loc_flat[8:0]), 176'(438));
    chk("t3_slot1_loc", 176'(unit_loc_flat[17:9]), 176'(41));
    check_state("t3");

    repeat (198) tick(-1);
    chk("t4_cat_at_42", 176'(unit_loc_flat[8:0]), 176'(42));

    // fill every slot, then hold a cat request while full
    repeat (6) spawn(1'b1, 1'b1, 2'($urandom_range(1, 2)));
    chk("t5_full", 176'(slots_full), 176'(1));
    check_state("t5_full");
    spawn(1'b1, 1'b0, 2'b10);
    check_state("t5_held");
    he0 = hits_en_seen;
    tick(-1);
    chk("t4_base_hit_enemy_pulses", 176'(hits_en_seen - he0), 176'(2));
    chk("t5_held_into_slot0", 176'({unit_type_flat[1:0], unit_loc_flat[8:0]}), 176'({2'b10, 9'd440}));
    check_state("t5_regrant");

    hc0 = hits_cat_seen;
    repeat (200) tick(-1);
    chk("t4_base_hit_cat_pulses", 176'(hits_cat_seen - hc0), 176'(2));
    check_state("t4_enemy_retire");

    // reset in the middle of a sweep
    do_reset();
    spawn(1'b1, 1'b1, 2'b01);
    gameSCEN = 1'b1;
    step();
    repeat (7) step();
    rst = 1'b1;
    step();
    chk("t6_pulses_in_reset",
        176'({cat_ack, enemy_ack, base_hit_cat, base_hit_enemy, tick_overrun}), 176'(0));
    rst = 1'b0;
    model_clear();
    step();
    check_state("t6_cleared");
    spawn(1'b1, 1'b1, 2'b01);
    tick(-1);
    chk("t6_cat_moves", 176'(unit_loc_flat[8:0]), 176'(438));
    chk("t6_enemy_moves", 176'(unit_loc_flat[17:9]), 176'(41));
    check_state("t6_resweep");

    // randomised mix of spawns, ticks, overruns and tick bursts
    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 2)      spawn(1'b1, 1'b0, 2'($urandom_range(0, 2)));
      else if (op <= 4) spawn(1'b0, 1'b1, 2'b01);
      else if (op == 5) spawn(1'b1, 1'b1, 2'($urandom_range(0, 2)));
      else if (op <= 7) begin
        ov = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
        tick(ov);
      end else repeat (15) tick(-1);
      check_state("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
